// File: rtl/mimm_dpram_pkg.sv
// Shared types and helpers for the PKE dual-port RAM wrapper and its array core.
// A stored lane is one data byte plus its even-parity bit.
package mimm_dpram_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned LaneW = ByteW + 1;

  typedef struct packed {
    logic             par;
    logic [ByteW-1:0] data;
  } lane_t;

  typedef enum logic [1:0] {
    StIdle,
    StClr,
    StDone
  } init_st_e;

  function automatic int unsigned nb_of(input int unsigned dw);
    return dw / ByteW;
  endfunction

  function automatic lane_t lane_gen(input logic [ByteW-1:0] b);
    lane_t l;
    l.par  = ^b;
    l.data = b;
    return l;
  endfunction

  function automatic logic lane_bad(input lane_t l);
    return l.par != (^l.data);
  endfunction

endpackage

// File: rtl/mimm_dpram_pe_core.sv
// Bare two-port lane array: per-lane write enables, read-old, one-cycle registered read.
// Swap this file for a macro or FPGA primitive wrapper without touching the top.
module mimm_dpram_pe_core
  import mimm_dpram_pkg::*;
#(
  parameter int unsigned AW   = 8,
  parameter int unsigned DCNT = 256,
  parameter int unsigned NB   = 8
) (
  input  logic                clk_i,
  input  logic                wclk_en_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [NB-1:0]       wlane_en_i,
  input  logic [NB*LaneW-1:0] wdata_i,
  input  logic                rclk_en_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [NB*LaneW-1:0] rdata_o
);

  logic [NB*LaneW-1:0] mem_q [DCNT];
  logic [NB*LaneW-1:0] rdata_q;

  // The clock enables model the write/read clock gates of a real macro.
  always_ff @(posedge clk_i) begin
    if (wclk_en_i) begin
      for (int i = 0; i < NB; i++) begin
        if (wlane_en_i[i]) begin
          mem_q[waddr_i][i*LaneW +: LaneW] <= wdata_i[i*LaneW +: LaneW];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rclk_en_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mimm_dpram_pe.sv
// Dual-port RAM wrapper: byte-lane writes, parity, write-first forwarding, selectable
// read latency, parity error log and a self-clearing init sequencer.
module mimm_dpram_pe
  import mimm_dpram_pkg::*;
#(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 64,
  parameter int unsigned DCNT  = 2**AW,
  parameter int unsigned RDLAT = 1,
  parameter int unsigned ECW   = 8,
  localparam int unsigned NB   = nb_of(DW)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           cmsatpg,
  input  logic [AW-1:0]  waddr,
  input  logic           wr,
  input  logic [NB-1:0]  wbe,
  input  logic [DW-1:0]  wdata,
  input  logic [AW-1:0]  raddr,
  input  logic           rd,
  output logic [DW-1:0]  rdata,
  output logic           rvld,
  output logic           parityerr,
  output logic [ECW-1:0] errcnt,
  output logic [AW-1:0]  erraddr,
  output logic           errvld,
  input  logic           errclr,
  input  logic           initreq,
  output logic           initbusy
);

  localparam logic [AW-1:0] LastAddr = AW'(DCNT - 1);

  init_st_e       st_q;
  logic [AW-1:0]  clr_addr_q;
  logic           initbusy_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q       <= StIdle;
      clr_addr_q <= '0;
      initbusy_q <= 1'b0;
    end else begin
      case (st_q)
        StIdle: if (initreq) begin
          st_q       <= StClr;
          clr_addr_q <= '0;
          initbusy_q <= 1'b1;
        end
        StClr: begin
          if (clr_addr_q == LastAddr) st_q <= StDone;
          else clr_addr_q <= clr_addr_q + AW'(1);
        end
        StDone: begin
          st_q       <= StIdle;
          initbusy_q <= 1'b0;
        end
        default: begin
          st_q       <= StIdle;
          initbusy_q <= 1'b0;
        end
      endcase
    end
  end

  logic                we_ext, re_ext, clr_we;
  logic [AW-1:0]       arr_waddr;
  logic [NB-1:0]       arr_lane_en;
  lane_t [NB-1:0]      ext_word, arr_wdata, arr_rdata, s1_word, fin_word;

  assign we_ext = wr & ~initbusy_q & (|wbe);
  assign re_ext = rd & ~initbusy_q;
  assign clr_we = (st_q == StClr);

  always_comb begin
    for (int i = 0; i < NB; i++) ext_word[i] = lane_gen(wdata[i*ByteW +: ByteW]);
  end

  always_comb begin
    arr_waddr   = clr_we ? clr_addr_q : waddr;
    arr_lane_en = clr_we ? '1 : (we_ext ? wbe : '0);
    arr_wdata   = clr_we ? '0 : ext_word;
  end

  mimm_dpram_pe_core #(
    .AW   (AW),
    .DCNT (DCNT),
    .NB   (NB)
  ) u_core (
    .clk_i      (clk),
    .wclk_en_i  ((|arr_lane_en) | cmsatpg),
    .waddr_i    (arr_waddr),
    .wlane_en_i (arr_lane_en),
    .wdata_i    (arr_wdata),
    .rclk_en_i  (re_ext | cmsatpg),
    .raddr_i    (raddr),
    .rdata_o    (arr_rdata)
  );

  // Stage 1 carries the address and the write-first bypass alongside the array read.
  logic           vld1_q;
  logic [AW-1:0]  addr1_q;
  logic [NB-1:0]  fwd_en_q;
  lane_t [NB-1:0] fwd_word_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld1_q     <= 1'b0;
      addr1_q    <= '0;
      fwd_en_q   <= '0;
      fwd_word_q <= '0;
    end else begin
      vld1_q <= re_ext;
      if (re_ext) begin
        addr1_q    <= raddr;
        fwd_en_q   <= (we_ext && (waddr == raddr)) ? wbe : '0;
        fwd_word_q <= ext_word;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NB; i++) s1_word[i] = fwd_en_q[i] ? fwd_word_q[i] : arr_rdata[i];
  end

  logic          fin_vld;
  logic [AW-1:0] fin_addr;

  if (RDLAT >= 2) begin : g_out_reg
    logic           vld2_q;
    logic [AW-1:0]  addr2_q;
    lane_t [NB-1:0] word2_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        vld2_q  <= 1'b0;
        addr2_q <= '0;
        word2_q <= '0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) begin
          addr2_q <= addr1_q;
          word2_q <= s1_word;
        end
      end
    end

    assign fin_vld  = vld2_q;
    assign fin_addr = addr2_q;
    assign fin_word = word2_q;
  end else begin : g_no_out_reg
    assign fin_vld  = vld1_q;
    assign fin_addr = addr1_q;
    assign fin_word = s1_word;
  end

  logic [DW-1:0] fin_data, rdata_q;
  logic          fin_bad;

  always_comb begin
    fin_data = '0;
    fin_bad  = 1'b0;
    for (int i = 0; i < NB; i++) begin
      fin_data[i*ByteW +: ByteW] = fin_word[i].data;
      fin_bad                    = fin_bad | lane_bad(fin_word[i]);
    end
  end

  logic [ECW-1:0] errcnt_q, errcnt_d;
  logic [AW-1:0]  erraddr_q, erraddr_d;
  logic           errvld_q, errvld_d;

  // A clear in the same cycle as a failure still logs that failure.
  always_comb begin
    errcnt_d  = errcnt_q;
    erraddr_d = erraddr_q;
    errvld_d  = errvld_q;
    if (errclr) begin
      errcnt_d  = '0;
      erraddr_d = '0;
      errvld_d  = 1'b0;
    end
    if (parityerr) begin
      if (errcnt_d != '1) errcnt_d = errcnt_d + ECW'(1);
      if (!errvld_d) begin
        erraddr_d = fin_addr;
        errvld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= '0;
      errcnt_q  <= '0;
      erraddr_q <= '0;
      errvld_q  <= 1'b0;
    end else begin
      if (fin_vld) rdata_q <= fin_data;
      errcnt_q  <= errcnt_d;
      erraddr_q <= erraddr_d;
      errvld_q  <= errvld_d;
    end
  end

  assign rvld      = fin_vld;
  assign parityerr = fin_vld & fin_bad;
  assign rdata     = fin_vld ? fin_data : rdata_q;
  assign errcnt    = errcnt_q;
  assign erraddr   = erraddr_q;
  assign errvld    = errvld_q;
  assign initbusy  = initbusy_q;

endmodule
